pipe_scheduler: RTL and testbench

Sequences the four-obstacle pipe datapath that feeds the VGA renderer. It holds the X/Y edges for pipes O1..O4 and scrolls them left once per video frame. Pipes that leave the screen are respawned on the right with a pseudo-random gap height, and a score is counted as each pipe clears the bird column. The block sits between the game FSM (start/halt) and vga_output, and is clocked by the same pixel clock as hvsync_generator.

---
 rtl/pipe_scheduler_if.sv | 31 +++
 rtl/pipe_scheduler.sv | 129 ++++++++++++
 tb/tb_pipe_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scheduler_if.sv
// Pipe scheduler bus: game-side controls in, per-pipe edges and score out.
interface pipe_scheduler_if;
  logic       frame_tick;
  logic       start;
  logic       halt;
  logic [9:0] X_Edge_O1;
  logic [9:0] X_Edge_O2;
  logic [9:0] X_Edge_O3;
  logic [9:0] X_Edge_O4;
  logic [9:0] Y_Edge_O1;
  logic [9:0] Y_Edge_O2;
  logic [9:0] Y_Edge_O3;
  logic [9:0] Y_Edge_O4;
  logic       running;
  logic       pass_pulse;
  logic [7:0] score;

  modport master (
    output frame_tick, start, halt,
    input  X_Edge_O1, X_Edge_O2, X_Edge_O3, X_Edge_O4,
    input  Y_Edge_O1, Y_Edge_O2, Y_Edge_O3, Y_Edge_O4,
    input  running, pass_pulse, score
  );

  modport slave (
    input  frame_tick, start, halt,
    output X_Edge_O1, X_Edge_O2, X_Edge_O3, X_Edge_O4,
    output Y_Edge_O1, Y_Edge_O2, Y_Edge_O3, Y_Edge_O4,
    output running, pass_pulse, score
  );
endinterface

// File: rtl/pipe_scheduler.sv
// Four-pipe scroller: per-frame left scroll, LFSR-driven respawn heights,
// bird-column pass detection and saturating score.
module pipe_scheduler #(
  parameter int unsigned PIPE_W      = 80,
  parameter int unsigned PIPE_SPACING = 160,
  parameter int unsigned SCROLL_STEP = 2,
  parameter int unsigned START_X     = 320,
  parameter int unsigned Y_INIT      = 190,
  parameter int unsigned Y_MIN       = 40,
  parameter int unsigned BIRD_X      = 320,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic           clk,
  input logic           reset,
  pipe_scheduler_if.slave bus
);
  localparam int unsigned N_PIPES = 4;
  localparam int unsigned XW      = 10;
  localparam int unsigned AW      = 11;
  localparam int unsigned SW      = 8;

  localparam logic [AW-1:0] STEP_A   = AW'(SCROLL_STEP);
  localparam logic [AW-1:0] WRAP_A   = AW'(4 * PIPE_SPACING);
  localparam logic [AW-1:0] PIPE_W_A = AW'(PIPE_W);
  localparam logic [AW-1:0] BIRD_A   = AW'(BIRD_X);
  localparam logic [XW-1:0] Y_INIT_V = XW'(Y_INIT);
  localparam logic [XW-1:0] Y_MIN_V  = XW'(Y_MIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

  state_e                       state_q, state_d;
  logic [N_PIPES-1:0][XW-1:0]   x_q, x_d;
  logic [N_PIPES-1:0][XW-1:0]   y_q, y_d;
  logic [SW-1:0]                score_q, score_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic                         pass_q, running_q;
  logic                         hit, reload;
  logic [AW-1:0]                x_old, x_new;

  function automatic logic [XW-1:0] start_x(input int unsigned k);
    return XW'(START_X + k * PIPE_SPACING);
  endfunction

  // Next-state and per-pipe datapath
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    score_d = score_q;
    hit     = 1'b0;
    reload  = 1'b0;
    x_old   = '0;
    x_new   = '0;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      S_RUN: begin
        if (bus.halt) begin
          state_d = S_STOP;
        end else if (bus.frame_tick) begin
          for (int unsigned k = 0; k < N_PIPES; k++) begin
            x_old = {1'b0, x_q[k]};
            if (x_old < STEP_A) begin
              x_new  = x_old + WRAP_A - STEP_A;
              y_d[k] = Y_MIN_V + XW'(lfsr_q[2*k +: 8]);
            end else begin
              x_new = x_old - STEP_A;
              if ((x_old + PIPE_W_A > BIRD_A) && (x_new + PIPE_W_A <= BIRD_A))
                hit = 1'b1;
            end
            x_d[k] = x_new[XW-1:0];
          end
        end
      end
      default: begin
        // IDLE and STOP share the restart path; halt is ignored here
        if (bus.start) begin
          state_d = S_RUN;
          reload  = 1'b1;
        end
      end
    endcase

    if (reload) begin
      for (int unsigned k = 0; k < N_PIPES; k++) begin
        x_d[k] = start_x(k);
        y_d[k] = Y_INIT_V;
      end
      score_d = '0;
    end else if (hit && (score_q != {SW{1'b1}})) begin
      score_d = score_q + SW'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      for (int unsigned k = 0; k < N_PIPES; k++) begin
        x_q[k] <= start_x(k);
        y_q[k] <= Y_INIT_V;
      end
      score_q   <= '0;
      pass_q    <= 1'b0;
      running_q <= 1'b0;
      lfsr_q    <= SEED;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      score_q   <= score_d;
      pass_q    <= hit;
      running_q <= (state_d == S_RUN);
      lfsr_q    <= lfsr_d;
    end
  end

  assign bus.X_Edge_O1  = x_q[0];
  assign bus.X_Edge_O2  = x_q[1];
  assign bus.X_Edge_O3  = x_q[2];
  assign bus.X_Edge_O4  = x_q[3];
  assign bus.Y_Edge_O1  = y_q[0];
  assign bus.Y_Edge_O2  = y_q[1];
  assign bus.Y_Edge_O3  = y_q[2];
  assign bus.Y_Edge_O4  = y_q[3];
  assign bus.running    = running_q;
  assign bus.pass_pulse = pass_q;
  assign bus.score      = score_q;
endmodule

// File: tb/tb_pipe_scheduler.sv
// Randomized and directed bench for pipe_scheduler against a behavioural model.
module tb_pipe_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;

  pipe_scheduler_if bus ();

  pipe_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;

  // Behavioural model: IDLE and STOP are indistinguishable, so one run flag suffices
  int unsigned m_x[4];
  int unsigned m_y[4];
  int unsigned m_score = 0;
  int unsigned m_lfsr  = 16'hACE1;
  bit          m_run   = 1'b0;
  bit          m_pass  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input int unsigned exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned v);
    int unsigned fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic logic [9:0] dut_x(input int k);
    case (k)
      0: return bus.X_Edge_O1;
      1: return bus.X_Edge_O2;
      2: return bus.X_Edge_O3;
      default: return bus.X_Edge_O4;
    endcase
  endfunction

  function automatic logic [9:0] dut_y(input int k);
    case (k)
      0: return bus.Y_Edge_O1;
      1: return bus.Y_Edge_O2;
      2: return bus.Y_Edge_O3;
      default: return bus.Y_Edge_O4;
    endcase
  endfunction

  task automatic model_load();
    for (int k = 0; k < 4; k++) begin
      m_x[k] = 320 + 160 * k;
      m_y[k] = 190;
    end
    m_score = 0;
  endtask

  always @(posedge clk) begin
    int unsigned cur;
    bit          hit;
    if (reset) begin
      model_load();
      m_run  = 1'b0;
      m_pass = 1'b0;
      m_lfsr = 16'hACE1;
    end else begin
      cur = m_lfsr;
      hit = 1'b0;
      if (!m_run) begin
        if (bus.start) begin
          m_run = 1'b1;
          model_load();
        end
      end else if (bus.halt) begin
        m_run = 1'b0;
      end else if (bus.frame_tick) begin
        for (int k = 0; k < 4; k++) begin
          if (m_x[k] < 2) begin
            m_x[k] = m_x[k] + 640 - 2;
            m_y[k] = 40 + ((cur >> (2 * k)) & 8'hFF);
          end else begin
            if (m_x[k] + 80 > 320 && m_x[k] - 2 + 80 <= 320) hit = 1'b1;
            m_x[k] = m_x[k] - 2;
          end
        end
      end
      m_pass = hit;
      if (hit && m_score < 255) m_score++;
      m_lfsr = lfsr_next(cur);
    end
  end

  // Scoreboard compares every output each cycle away from the active edge
  always @(negedge clk) begin
    if (sb_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("sb_x%0d", k + 1), 32'(dut_x(k)), m_x[k]);
        check($sformatf("sb_y%0d", k + 1), 32'(dut_y(k)), m_y[k]);
      end
      check("sb_running", 32'(bus.running), 32'(m_run));
      check("sb_pass", 32'(bus.pass_pulse), 32'(m_pass));
      check("sb_score", 32'(bus.score), m_score);
    end
  end

  task automatic cyc(input bit ft, input bit st, input bit ht);
    bus.frame_tick = ft;
    bus.start      = st;
    bus.halt       = ht;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_x1"}, 32'(bus.X_Edge_O1), 320);
    check({pfx, "_x2"}, 32'(bus.X_Edge_O2), 480);
    check({pfx, "_x3"}, 32'(bus.X_Edge_O3), 640);
    check({pfx, "_x4"}, 32'(bus.X_Edge_O4), 800);
    for (int k = 0; k < 4; k++) check($sformatf("%s_y%0d", pfx, k + 1), 32'(dut_y(k)), 190);
    check({pfx, "_running"}, 32'(bus.running), 0);
    check({pfx, "_score"}, 32'(bus.score), 0);
    check({pfx, "_pass"}, 32'(bus.pass_pulse), 0);
  endtask

  task automatic respawn_run(input string pfx);
    logic [9:0] y1;
    cyc(1'b0, 1'b1, 1'b0);
    ticks(160);
    check({pfx, "_x1_at160"}, 32'(bus.X_Edge_O1), 0);
    ticks(1);
    y1 = bus.Y_Edge_O1;
    check({pfx, "_x1_respawn"}, 32'(bus.X_Edge_O1), 638);
    check({pfx, "_y1_respawn"}, 32'(y1), m_y[0]);
    check({pfx, "_y1_range"}, 32'(y1 >= 10'd40 && y1 <= 10'd295), 1);
    check({pfx, "_x2"}, 32'(bus.X_Edge_O2), 158);
    check({pfx, "_x3"}, 32'(bus.X_Edge_O3), 318);
    check({pfx, "_x4"}, 32'(bus.X_Edge_O4), 478);
  endtask

  initial begin
    logic [9:0] hx[4];
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.halt       = 1'b0;

    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    sb_en = 1'b1;
    check_reset_state("rst");

    // Idle ignores ticks and halt
    ticks(10);
    cyc(1'b0, 1'b0, 1'b1);
    check_reset_state("idle");

    // Start, first scroll and first pass
    cyc(1'b0, 1'b1, 1'b0);
    check("start_running", 32'(bus.running), 1);
    ticks(1);
    check("t1_x1", 32'(bus.X_Edge_O1), 318);
    check("t1_x2", 32'(bus.X_Edge_O2), 478);
    check("t1_x3", 32'(bus.X_Edge_O3), 638);
    check("t1_x4", 32'(bus.X_Edge_O4), 798);
    check("t1_y1", 32'(bus.Y_Edge_O1), 190);
    check("t1_pass", 32'(bus.pass_pulse), 0);
    ticks(38);
    check("t39_pass", 32'(bus.pass_pulse), 0);
    ticks(1);
    check("t40_x1", 32'(bus.X_Edge_O1), 240);
    check("t40_pass", 32'(bus.pass_pulse), 1);
    check("t40_score", 32'(bus.score), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("pass_one_cycle", 32'(bus.pass_pulse), 0);
    ticks(1);
    check("t41_pass", 32'(bus.pass_pulse), 0);
    check("t41_score", 32'(bus.score), 1);
    check("t41_x1", 32'(bus.X_Edge_O1), 238);

    // Pipe 1 reaches 0 then respawns; pipe 2 passes on the way
    ticks(119);
    check("t160_x1", 32'(bus.X_Edge_O1), 0);
    check("t160_x2", 32'(bus.X_Edge_O2), 160);
    check("t160_score", 32'(bus.score), 2);
    ticks(1);
    check("t161_x1", 32'(bus.X_Edge_O1), 638);
    check("t161_y1", 32'(bus.Y_Edge_O1), m_y[0]);
    check("t161_x2", 32'(bus.X_Edge_O2), 158);
    check("t161_x3", 32'(bus.X_Edge_O3), 318);
    check("t161_x4", 32'(bus.X_Edge_O4), 478);

    // Halt beats a coincident tick, later ticks are ignored
    for (int k = 0; k < 4; k++) hx[k] = dut_x(k);
    cyc(1'b1, 1'b0, 1'b1);
    check("halt_running", 32'(bus.running), 0);
    for (int k = 0; k < 4; k++) check($sformatf("halt_x%0d", k + 1), 32'(dut_x(k)), 32'(hx[k]));
    ticks(5);
    check("stop_x1", 32'(bus.X_Edge_O1), 32'(hx[0]));
    check("stop_score", 32'(bus.score), 2);
    cyc(1'b0, 1'b1, 1'b1);
    check("restart_running", 32'(bus.running), 1);
    check("restart_x1", 32'(bus.X_Edge_O1), 320);
    check("restart_x4", 32'(bus.X_Edge_O4), 800);
    check("restart_score", 32'(bus.score), 0);

    // Random control traffic, including occasional resets
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 59) == 0));
    end
    reset = 1'b0;

    // Saturation: forced restart then ~262 passes
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check("sat_start_score", 32'(bus.score), 0);
    check("sat_start_running", 32'(bus.running), 1);
    ticks(21000);
    check("sat_score", 32'(bus.score), 255);

    // Reset asserted mid-run, then a fresh respawn against the model LFSR
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    check_reset_state("midrst");
    respawn_run("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
